lfsr_share_ctrl: RTL and testbench
==================================

// Module: lfsr_share_ctrl
// PURPOSE
//  Sequencer/arbiter for the 26-bit LFSR random source (ports q/load/din/rst_n).
//  Resets the LFSR, loads its seed, discards warm-up words, then shares the word
//  stream among NREQ requesters with round-robin arbitration and a valid/ready
//  output slot. Periodically and on software seed writes, re-seeds the LFSR.
// PARAMETERS
//  NREQ          4            number of requesters (2..16)
//  SEED_INIT     26'h2A5F3C1  seed_reg reset value (must be nonzero)
//  WARMUP        4            LFSR steps discarded after every seed load (1..255)
//  RESEED_PERIOD 1024         words delivered between auto re-seeds; 0 = disabled
// PORTS
//  clk         in   1     clock, all logic on posedge
//  rst_n       in   1     asynchronous active-low reset
//  req         in   NREQ  level request per requester
//  gnt         out  NREQ  one-hot, 1-cycle pulse: word captured for that requester
//  rnd_vld     out  1     output slot holds a word
//  rnd_rdy     in   1     consumer accepts slot (transfer when rnd_vld&rnd_rdy)
//  rnd_id      out  4     requester index owning the slot word
//  rnd_data    out  26    random word
//  seed_we     in   1     1-cycle strobe: write seed_wdata, request re-seed
//  seed_wdata  in   26    new seed value
//  busy        out  1     1 while not in RUN
//  lfsr_rst_n  out  1     drives LFSR rst_n (synchronous reset of LFSR)
//  lfsr_load   out  1     drives LFSR load
//  lfsr_din    out  26    drives LFSR din
//  lfsr_q      in   26    LFSR q
// BEHAVIOUR
//  Reset (async): state=CLR; lfsr_rst_n=0, lfsr_load=0, lfsr_din=0, gnt=0,
//   rnd_vld=0, rnd_id=0, rnd_data=0, busy=1, seed_reg=SEED_INIT, word_cnt=0,
//   rr_ptr=NREQ-1, reseed_pend=0. All outputs registered.
//  FSM:
//   CLR : lfsr_rst_n=0 for exactly 1 cycle -> SEED.
//   SEED: lfsr_rst_n=1, lfsr_load=1 for 1 cycle, lfsr_din = seed_src -> WARM.
//         seed_src = seed_reg after reset or seed_we; seed_reg^lfsr_q on auto re-seed
//         (all-zero din is acceptable: LFSR substitutes 1).
//   WARM: count WARMUP cycles, lfsr_load=0, no capture -> RUN.
//   RUN : busy=0; arbitrate each cycle (below). When reseed_pend=1 and slot empty
//         (rnd_vld=0, or transfer this cycle), clear reseed_pend -> SEED.
//  Capture (RUN only, reseed_pend=0): when slot free (rnd_vld=0 or transfer this
//   cycle) and |req: winner = first set req index scanning rr_ptr+1 upward mod
//   NREQ; same edge: gnt[winner]=1 (next cycle only), rnd_data<=lfsr_q,
//   rnd_id<=winner, rnd_vld<=1, rr_ptr<=winner. Back-to-back capture allowed:
//   one word per cycle at full throughput. No free slot or no req -> gnt=0.
//  Slot: while rnd_vld&!rnd_rdy, rnd_data/rnd_id stable. Transfer without new
//   capture -> rnd_vld<=0.
//  word_cnt: +1 per transfer, 16-bit; when RESEED_PERIOD!=0 and count reaches
//   RESEED_PERIOD: word_cnt<=0, reseed_pend<=1.
//  seed_we: seed_reg<=seed_wdata (any state), reseed_pend<=1, word_cnt<=0.
//   seed_we during SEED/WARM: new seed used on a fresh SEED after returning to RUN.
//   seed_we with seed_wdata=0: seed_reg keeps 26'h1.
//  Simultaneous auto-reseed and seed_we: single re-seed, seed_reg=seed_wdata
//   (no XOR).
//  Requesters drop req on their gnt; req sampled every RUN cycle.
//  rst_n low mid-operation: immediate return to reset values, slot word lost.
// TESTING
//  Reset release, req=0 -> lfsr_rst_n low 1 cycle, lfsr_load pulse with
//   din=26'h2A5F3C1, busy low after WARMUP=4 cycles, then gnt stays 0.
//  req=4'b1111, rnd_rdy=1 -> rnd_id sequence 0,1,2,3,0 on consecutive cycles;
//   rnd_data equals lfsr_q sampled on each capture edge.
//  req=4'b0101, rnd_rdy=0 for 5 cycles -> one gnt only; rnd_data/rnd_id frozen;
//   on rnd_rdy=1 next id is 2.
//  RESEED_PERIOD=4 -> after 4th transfer: busy=1, lfsr_load pulse with
//   din=seed_reg^lfsr_q, WARMUP idle cycles, word_cnt=0, then captures resume.
//  seed_we=1, seed_wdata=0 while slot stalled -> no re-seed until transfer,
//   then load pulse with din=26'h1.
//  Assert rst_n=0 mid-burst -> all outputs at reset values in same cycle; full
//   CLR/SEED/WARM sequence reruns with SEED_INIT.

Source files
------------

// File: rtl/lfsr_share_ctrl.sv
// Sequencer and round-robin arbiter that shares an external 26-bit LFSR word stream.
// Drives the LFSR through reset, seed load and warm-up, and re-seeds it periodically or on request.
module lfsr_share_ctrl #(
    parameter int          NREQ          = 4,
    parameter logic [25:0] SEED_INIT     = 26'h2A5F3C1,
    parameter int          WARMUP        = 4,
    parameter int          RESEED_PERIOD = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic            rnd_vld,
    input  logic            rnd_rdy,
    output logic [3:0]      rnd_id,
    output logic [25:0]     rnd_data,
    input  logic            seed_we,
    input  logic [25:0]     seed_wdata,
    output logic            busy,
    output logic            lfsr_rst_n,
    output logic            lfsr_load,
    output logic [25:0]     lfsr_din,
    input  logic [25:0]     lfsr_q
);

    localparam int          PW        = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [7:0]  WARM_LAST = 8'(WARMUP - 1);

    typedef enum logic [1:0] {CLR, SEED, WARM, RUN} state_e;

    state_e          state_q, state_d;
    logic [7:0]      warm_cnt_q, warm_cnt_d;
    logic [25:0]     seed_reg_q, seed_reg_d;
    logic            seed_xor_q, seed_xor_d;
    logic [15:0]     word_cnt_q, word_cnt_d;
    logic            reseed_pend_q, reseed_pend_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            rnd_vld_q, rnd_vld_d;
    logic [3:0]      rnd_id_q, rnd_id_d;
    logic [25:0]     rnd_data_q, rnd_data_d;
    logic            busy_q, busy_d;
    logic            lfsr_rst_n_q, lfsr_rst_n_d;
    logic            lfsr_load_q, lfsr_load_d;
    logic [25:0]     lfsr_din_q, lfsr_din_d;

    logic            xfer, slot_free, capture, win_found;
    logic [PW-1:0]   win_idx;
    logic [25:0]     seed_src;
    int              scan_idx;

    // Round-robin: first requester above the last winner, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        for (int i = 1; i <= NREQ; i++) begin
            scan_idx = (int'(rr_ptr_q) + i) % NREQ;
            if (!win_found && req[scan_idx[PW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan_idx[PW-1:0];
            end
        end
    end

    // Output slot handshake: a word moves on an edge where rnd_vld and rnd_rdy are both high;
    // while rnd_vld is high and rnd_rdy low, rnd_id/rnd_data hold their value.
    always_comb begin
        state_d       = state_q;
        warm_cnt_d    = warm_cnt_q;
        seed_reg_d    = seed_reg_q;
        seed_xor_d    = seed_xor_q;
        word_cnt_d    = word_cnt_q;
        reseed_pend_d = reseed_pend_q;
        rr_ptr_d      = rr_ptr_q;
        rnd_vld_d     = rnd_vld_q;
        rnd_id_d      = rnd_id_q;
        rnd_data_d    = rnd_data_q;
        gnt_d         = '0;
        capture       = 1'b0;
        xfer          = rnd_vld_q & rnd_rdy;
        slot_free     = ~rnd_vld_q | rnd_rdy;
        seed_src      = seed_xor_q ? (seed_reg_q ^ lfsr_q) : seed_reg_q;

        case (state_q)
            CLR:  state_d = SEED;
            SEED: begin
                state_d    = WARM;
                warm_cnt_d = '0;
            end
            WARM: begin
                if (warm_cnt_q == WARM_LAST) begin
                    state_d = RUN;
                end else begin
                    warm_cnt_d = warm_cnt_q + 8'd1;
                end
            end
            RUN: begin
                if (reseed_pend_q) begin
                    if (slot_free) begin
                        state_d       = SEED;
                        reseed_pend_d = 1'b0;
                    end
                end else if (slot_free && (|req)) begin
                    capture = 1'b1;
                end
            end
            default: state_d = CLR;
        endcase

        if (capture) begin
            gnt_d[win_idx] = 1'b1;
            rnd_vld_d      = 1'b1;
            rnd_id_d       = 4'(win_idx);
            rnd_data_d     = lfsr_q;
            rr_ptr_d       = win_idx;
        end else if (xfer) begin
            rnd_vld_d = 1'b0;
        end

        // Auto re-seed mixes the current LFSR state into the stored seed.
        if (xfer) begin
            if (RESEED_PERIOD != 0 && (int'(word_cnt_q) + 1) == RESEED_PERIOD) begin
                word_cnt_d    = '0;
                reseed_pend_d = 1'b1;
                seed_xor_d    = 1'b1;
            end else begin
                word_cnt_d = word_cnt_q + 16'd1;
            end
        end

        // A software seed always wins over a coincident auto re-seed.
        if (seed_we) begin
            seed_reg_d    = (seed_wdata == '0) ? 26'h1 : seed_wdata;
            seed_xor_d    = 1'b0;
            reseed_pend_d = 1'b1;
            word_cnt_d    = '0;
        end

        busy_d       = (state_d != RUN);
        lfsr_rst_n_d = (state_d != CLR);
        lfsr_load_d  = (state_d == SEED);
        lfsr_din_d   = (state_d == SEED) ? seed_src : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= CLR;
            warm_cnt_q    <= '0;
            seed_reg_q    <= SEED_INIT;
            seed_xor_q    <= 1'b0;
            word_cnt_q    <= '0;
            reseed_pend_q <= 1'b0;
            rr_ptr_q      <= PW'(NREQ - 1);
            gnt_q         <= '0;
            rnd_vld_q     <= 1'b0;
            rnd_id_q      <= '0;
            rnd_data_q    <= '0;
            busy_q        <= 1'b1;
            lfsr_rst_n_q  <= 1'b0;
            lfsr_load_q   <= 1'b0;
            lfsr_din_q    <= '0;
        end else begin
            state_q       <= state_d;
            warm_cnt_q    <= warm_cnt_d;
            seed_reg_q    <= seed_reg_d;
            seed_xor_q    <= seed_xor_d;
            word_cnt_q    <= word_cnt_d;
            reseed_pend_q <= reseed_pend_d;
            rr_ptr_q      <= rr_ptr_d;
            gnt_q         <= gnt_d;
            rnd_vld_q     <= rnd_vld_d;
            rnd_id_q      <= rnd_id_d;
            rnd_data_q    <= rnd_data_d;
            busy_q        <= busy_d;
            lfsr_rst_n_q  <= lfsr_rst_n_d;
            lfsr_load_q   <= lfsr_load_d;
            lfsr_din_q    <= lfsr_din_d;
        end
    end

    assign gnt        = gnt_q;
    assign rnd_vld    = rnd_vld_q;
    assign rnd_id     = rnd_id_q;
    assign rnd_data   = rnd_data_q;
    assign busy       = busy_q;
    assign lfsr_rst_n = lfsr_rst_n_q;
    assign lfsr_load  = lfsr_load_q;
    assign lfsr_din   = lfsr_din_q;

endmodule

// File: tb/tb_lfsr_share_ctrl.sv
// Bench for lfsr_share_ctrl: behavioural LFSR plus a phase-counting reference model,
// directed scenarios followed by randomized traffic, seed writes and resets.
module tb_lfsr_share_ctrl;

    localparam int          NREQ      = 4;
    localparam int          WARMUP    = 4;
    localparam int          PERIOD    = 4;
    localparam logic [25:0] SEED_INIT = 26'h2A5F3C1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0]      req;
    logic            rnd_rdy;
    logic            seed_we;
    logic [25:0]     seed_wdata;
    logic [25:0]     lfsr_q = 26'h1;
    logic [3:0]      gnt;
    logic            rnd_vld;
    logic [3:0]      rnd_id;
    logic [25:0]     rnd_data;
    logic            busy;
    logic            lfsr_rst_n;
    logic            lfsr_load;
    logic [25:0]     lfsr_din;

    int checks = 0;
    int errors = 0;

    lfsr_share_ctrl #(
        .NREQ(NREQ), .SEED_INIT(SEED_INIT), .WARMUP(WARMUP), .RESEED_PERIOD(PERIOD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .rnd_vld(rnd_vld),
        .rnd_rdy(rnd_rdy), .rnd_id(rnd_id), .rnd_data(rnd_data), .seed_we(seed_we),
        .seed_wdata(seed_wdata), .busy(busy), .lfsr_rst_n(lfsr_rst_n),
        .lfsr_load(lfsr_load), .lfsr_din(lfsr_din), .lfsr_q(lfsr_q)
    );

    always #5 clk = ~clk;

    // External LFSR: synchronous reset, load substitutes 1 for a zero seed.
    always @(posedge clk) begin
        if (!lfsr_rst_n)    lfsr_q <= 26'h1;
        else if (lfsr_load) lfsr_q <= (lfsr_din == '0) ? 26'h1 : lfsr_din;
        else                lfsr_q <= {lfsr_q[24:0], lfsr_q[25] ^ lfsr_q[5] ^ lfsr_q[1] ^ lfsr_q[0]};
    end

    // Reference model. m_since counts cycles since the last seed load:
    // -1 = LFSR held in reset, 0 = load cycle, 1..WARMUP = warm-up, beyond = running.
    int          m_since;
    bit          m_vld;
    logic [3:0]  m_id;
    logic [25:0] m_data;
    logic [3:0]  m_gnt;
    int          m_last;
    int          m_cnt;
    bit          m_pend;
    bit          m_xor;
    logic [25:0] m_seed;
    logic [25:0] m_din;

    task automatic model_reset();
        m_since = -1; m_vld = 0; m_id = '0; m_data = '0; m_gnt = '0;
        m_last = NREQ - 1; m_cnt = 0; m_pend = 0; m_xor = 0;
        m_seed = SEED_INIT; m_din = '0;
    endtask

    function automatic int pick(logic [3:0] r, int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_edge(logic [3:0] r, bit rdy, bit we, logic [25:0] wd, logic [25:0] q);
        bit          running = (m_since > WARMUP);
        bit          moved   = m_vld && rdy;
        bit          room    = !m_vld || rdy;
        bit          took    = 0;
        bit          loaded  = 0;
        logic [25:0] src     = m_xor ? (m_seed ^ q) : m_seed;
        int          w;
        m_gnt = '0;
        if (!running) begin
            m_since++;
            loaded = (m_since == 0);
        end else if (m_pend) begin
            if (room) begin
                m_since = 0;
                loaded  = 1;
                m_pend  = 0;
            end
        end else if (room && r != 0) begin
            w = pick(r, m_last);
            m_gnt[w] = 1'b1;
            m_data = q;
            m_id   = 4'(w);
            m_last = w;
            took   = 1;
        end
        if (took)       m_vld = 1;
        else if (moved) m_vld = 0;
        m_din = loaded ? src : '0;
        if (moved) begin
            m_cnt++;
            if (m_cnt == PERIOD) begin
                m_cnt = 0; m_pend = 1; m_xor = 1;
            end
        end
        if (we) begin
            m_seed = (wd == '0) ? 26'h1 : wd;
            m_pend = 1; m_cnt = 0; m_xor = 0;
        end
    endtask

    always @(posedge clk) begin
        if (rst_n) model_edge(req, rnd_rdy, seed_we, seed_wdata, lfsr_q);
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("gnt", 32'(gnt), 32'(m_gnt));
        chk("rnd_vld", 32'(rnd_vld), 32'(m_vld));
        chk("rnd_id", 32'(rnd_id), 32'(m_id));
        chk("rnd_data", 32'(rnd_data), 32'(m_data));
        chk("busy", 32'(busy), 32'(m_since <= WARMUP));
        chk("lfsr_rst_n", 32'(lfsr_rst_n), 32'(m_since != -1));
        chk("lfsr_load", 32'(lfsr_load), 32'(m_since == 0));
        if (m_since == 0) chk("lfsr_din", 32'(lfsr_din), 32'(m_din));
    endtask

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            check_all();
        end
    endtask

    task automatic check_reset_vals(string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'h0);
        chk({tag, "_vld"}, 32'(rnd_vld), 32'h0);
        chk({tag, "_id"}, 32'(rnd_id), 32'h0);
        chk({tag, "_data"}, 32'(rnd_data), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h1);
        chk({tag, "_lrst"}, 32'(lfsr_rst_n), 32'h0);
        chk({tag, "_load"}, 32'(lfsr_load), 32'h0);
        chk({tag, "_din"}, 32'(lfsr_din), 32'h0);
    endtask

    // Called on the load cycle; counts busy cycles that follow it.
    task automatic count_warm(string tag);
        int warm = 0;
        step();
        while (busy === 1'b1 && warm < 60) begin
            warm++;
            step();
        end
        chk(tag, 32'(warm), 32'(WARMUP));
    endtask

    // Called just after reset release, on the CLR cycle.
    task automatic check_boot(string tag);
        #1;
        chk({tag, "_clr_low"}, 32'(lfsr_rst_n), 32'h0);
        step();
        chk({tag, "_load"}, 32'(lfsr_load), 32'h1);
        chk({tag, "_din"}, 32'(lfsr_din), 32'(SEED_INIT));
        count_warm({tag, "_warm"});
        for (int i = 0; i < 3; i++) begin
            step();
            chk({tag, "_idle_gnt"}, 32'(gnt), 32'h0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [25:0] qb, d0;
        logic [3:0]  exp_ids [5];
        int          gnt_pulses;
        exp_ids = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};

        rst_n = 1'b1; req = '0; rnd_rdy = 1'b0; seed_we = 1'b0; seed_wdata = '0;
        model_reset();
        #2 rst_n = 1'b0;
        #1 check_reset_vals("por");
        step(2);
        rst_n = 1'b1;
        check_boot("boot");

        // Stalled slot keeps one word; the next winner after id 0 is id 2.
        req = 4'b0101; rnd_rdy = 1'b0;
        step();
        chk("stall_first_gnt", 32'(gnt), 32'h1);
        chk("stall_first_id", 32'(rnd_id), 32'h0);
        d0 = rnd_data;
        gnt_pulses = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (gnt != 0) gnt_pulses++;
            chk("stall_id_frozen", 32'(rnd_id), 32'h0);
            chk("stall_data_frozen", 32'(rnd_data), 32'(d0));
        end
        chk("stall_gnt_count", 32'(gnt_pulses), 32'h1);
        rnd_rdy = 1'b1;
        qb = lfsr_q;
        step();
        chk("stall_next_id", 32'(rnd_id), 32'h2);
        chk("stall_next_gnt", 32'(gnt), 32'h4);
        chk("stall_next_data", 32'(rnd_data), 32'(qb));
        step(3);

        // Asynchronous reset in the middle of a burst.
        rst_n = 1'b0;
        #1 check_reset_vals("midrst");
        model_reset();
        req = '0;
        step(2);
        rst_n = 1'b1;
        check_boot("reboot");

        // Full-throughput round robin, then the auto re-seed after the fourth transfer.
        req = 4'b1111; rnd_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            qb = lfsr_q;
            step();
            chk("rr_id", 32'(rnd_id), 32'(exp_ids[i]));
            chk("rr_vld", 32'(rnd_vld), 32'h1);
            chk("rr_data", 32'(rnd_data), 32'(qb));
        end
        req = '0;
        qb = lfsr_q;
        step();
        chk("auto_busy", 32'(busy), 32'h1);
        chk("auto_load", 32'(lfsr_load), 32'h1);
        chk("auto_din", 32'(lfsr_din), 32'(SEED_INIT ^ qb));
        count_warm("auto_warm");
        step();
        chk("auto_idle_gnt", 32'(gnt), 32'h0);

        // Zero seed written while the slot is stalled: re-seed waits for the transfer.
        req = 4'b0001; rnd_rdy = 1'b0;
        step();
        chk("sw_capture", 32'(rnd_vld), 32'h1);
        req = '0; seed_we = 1'b1; seed_wdata = '0;
        step();
        seed_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("sw_wait_busy", 32'(busy), 32'h0);
            chk("sw_wait_load", 32'(lfsr_load), 32'h0);
        end
        rnd_rdy = 1'b1;
        step();
        chk("sw_load", 32'(lfsr_load), 32'h1);
        chk("sw_din_one", 32'(lfsr_din), 32'h1);
        count_warm("sw_warm");

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            req        = 4'($urandom_range(0, 15));
            rnd_rdy    = ($urandom_range(0, 3) != 0);
            seed_we    = ($urandom_range(0, 49) == 0);
            seed_wdata = ($urandom_range(0, 3) == 0) ? 26'h0 : 26'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                seed_we = 1'b0;
                rst_n = 1'b0;
                #1 check_reset_vals("rand_rst");
                model_reset();
                step();
                rst_n = 1'b1;
            end else begin
                step();
            end
        end
        seed_we = 1'b0; req = '0;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
